mm_stream_mac: RTL and testbench

//  Streaming, time-multiplexed counterpart of the combinational 3x3 * 3x1 matrix-vector multiplier.
//  - Accepts A (row-major, 9 words) then B (3 words) serially on a valid/ready input port.
//  - Computes C = A*B using one signed MAC, one product per cycle.
//  - Returns C_11, C_21, C_31 serially on a valid/ready output port.
//  - Sits between the serial operand bus and result consumers where a 9-multiplier array is too costly.

---
 rtl/mm_stream_mac_pkg.sv | 27 ++
 rtl/mm_stream_mac_mac_unit.sv | 44 ++++
 rtl/mm_stream_mac.sv | 225 ++++++++++++++++++++++
 tb/tb_mm_stream_mac.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mm_stream_mac_pkg.sv
// Shared definitions for the streaming 3x3 * 3x1 matrix-vector MAC.
// Holds the default operand/product/result widths, the matrix dimension and the
// control FSM state encoding used by mm_stream_mac.
package mm_stream_mac_pkg;

   localparam int unsigned FACTOR_WIDTH_DEFAULT  = 8;
   localparam int unsigned PRODUCT_WIDTH_DEFAULT = 2 * FACTOR_WIDTH_DEFAULT;
   localparam int unsigned RESULT_WIDTH_DEFAULT  = 18;

   localparam int unsigned MM_DIM     = 3;
   localparam int unsigned MM_A_WORDS = MM_DIM * MM_DIM;
   localparam int unsigned MM_CNT_W   = 4;   // holds 0..MM_A_WORDS
   localparam int unsigned MM_IDX_W   = 2;   // holds 0..MM_DIM

   typedef enum logic [1:0] {
      MM_ST_LOAD_A  = 2'd0,
      MM_ST_LOAD_B  = 2'd1,
      MM_ST_COMPUTE = 2'd2,
      MM_ST_OUTPUT  = 2'd3
   } mm_state_e;

   // True in the states that accept operand words.
   function automatic logic mm_is_load(input mm_state_e st);
      return (st == MM_ST_LOAD_A) || (st == MM_ST_LOAD_B);
   endfunction

endpackage

// File: rtl/mm_stream_mac_mac_unit.sv
// mm_mac_unit: registered signed multiply-accumulate.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          perform one MAC step on this edge
//   clr         start a new sum (accumulate onto zero instead of acc)
//   a, b        signed NBITS operands
//   acc         signed RESULT_WIDTH running sum
module mm_mac_unit
   import mm_stream_mac_pkg::*;
#(
   parameter int unsigned NBITS        = FACTOR_WIDTH_DEFAULT,
   parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic [NBITS-1:0]        a,
   input  logic [NBITS-1:0]        b,
   output logic [RESULT_WIDTH-1:0] acc
);

   localparam int unsigned PW = 2 * NBITS;

   logic signed [PW-1:0]           prod;
   logic signed [RESULT_WIDTH-1:0] prod_ext;
   logic signed [RESULT_WIDTH-1:0] base;

   // Full-width signed product, sign-extended before accumulation.
   always_comb begin
      prod     = $signed(a) * $signed(b);
      prod_ext = RESULT_WIDTH'(prod);
      base     = clr ? '0 : $signed(acc);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         acc <= base + prod_ext;
      end
   end

endmodule

// File: rtl/mm_stream_mac.sv
// mm_stream_mac: streaming 3x3 * 3x1 matrix-vector multiplier using one MAC.
// Loads A (9 words, row-major) then B (3 words) over a valid/ready input,
// computes one product per cycle, then returns C[0..2] over a valid/ready output.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   in_data/in_valid/in_ready   operand stream
//   out_data/out_idx/out_last   result word, its row index, final-row flag
//   out_valid/out_ready         result handshake
//   busy                        high unless idle in LOAD_A with nothing loaded
module mm_stream_mac
   import mm_stream_mac_pkg::*;
#(
   parameter int unsigned NBITS        = FACTOR_WIDTH_DEFAULT,
   parameter int unsigned RESULT_WIDTH = RESULT_WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NBITS-1:0]        in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [RESULT_WIDTH-1:0] out_data,
   output logic [1:0]              out_idx,
   output logic                    out_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   mm_state_e state_q, state_d;

   logic [NBITS-1:0]        a_q   [MM_A_WORDS];
   logic [NBITS-1:0]        b_q   [MM_DIM];
   logic [RESULT_WIDTH-1:0] res_q [MM_DIM];

   logic [MM_CNT_W-1:0] ld_cnt_q, ld_cnt_d;
   logic [MM_CNT_W-1:0] mac_cnt_q, mac_cnt_d;
   logic [MM_IDX_W-1:0] col_q, col_d;
   logic [MM_IDX_W-1:0] row_q, row_d;
   logic [MM_IDX_W-1:0] out_row_q, out_row_d;
   logic [MM_IDX_W-1:0] out_row_nx;
   logic [MM_IDX_W-1:0] res_idx;

   logic                    out_valid_d, out_last_d, in_ready_d, busy_d;
   logic [RESULT_WIDTH-1:0] out_data_d;
   logic [1:0]              out_idx_d;

   logic                    in_fire, out_fire;
   logic                    a_wr, b_wr, res_wr;
   logic                    mac_en, mac_clr;
   logic [MM_CNT_W-1:0]     mac_idx;
   logic [NBITS-1:0]        mac_a, mac_b;
   logic [RESULT_WIDTH-1:0] mac_acc;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   mm_mac_unit #(
      .NBITS        (NBITS),
      .RESULT_WIDTH (RESULT_WIDTH)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (mac_en),
      .clr   (mac_clr),
      .a     (mac_a),
      .b     (mac_b),
      .acc   (mac_acc)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MM_ST_LOAD_A;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, counter and output-register logic.
   always_comb begin
      state_d     = state_q;
      ld_cnt_d    = ld_cnt_q;
      mac_cnt_d   = mac_cnt_q;
      col_d       = col_q;
      row_d       = row_q;
      out_row_d   = out_row_q;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      out_idx_d   = out_idx;
      out_last_d  = out_last;
      a_wr        = 1'b0;
      b_wr        = 1'b0;
      res_wr      = 1'b0;
      mac_en      = 1'b0;
      mac_clr     = 1'b0;
      mac_idx     = '0;
      out_row_nx  = out_row_q + 2'd1;
      res_idx     = row_q - 2'd1;

      unique case (state_q)
         MM_ST_LOAD_A: begin
            if (in_fire) begin
               a_wr = 1'b1;
               if (ld_cnt_q == MM_CNT_W'(MM_A_WORDS - 1)) begin
                  state_d  = MM_ST_LOAD_B;
                  ld_cnt_d = '0;
               end else begin
                  ld_cnt_d = ld_cnt_q + 4'd1;
               end
            end
         end

         MM_ST_LOAD_B: begin
            if (in_fire) begin
               b_wr = 1'b1;
               if (ld_cnt_q == MM_CNT_W'(MM_DIM - 1)) begin
                  state_d   = MM_ST_COMPUTE;
                  ld_cnt_d  = '0;
                  mac_cnt_d = '0;
                  col_d     = '0;
                  row_d     = '0;
               end else begin
                  ld_cnt_d = ld_cnt_q + 4'd1;
               end
            end
         end

         MM_ST_COMPUTE: begin
            // A row sum is complete in acc one cycle after its last MAC step;
            // the extra tenth cycle drains the final row into the buffer.
            res_wr = (col_q == '0) && (mac_cnt_q != '0);
            if (mac_cnt_q == MM_CNT_W'(MM_A_WORDS)) begin
               state_d     = MM_ST_OUTPUT;
               out_valid_d = 1'b1;
               out_row_d   = '0;
               out_idx_d   = '0;
               out_last_d  = 1'b0;
               out_data_d  = res_q[0];
            end else begin
               mac_en    = 1'b1;
               mac_clr   = (col_q == '0);
               mac_idx   = mac_cnt_q;   // row-major A index equals step count
               mac_cnt_d = mac_cnt_q + 4'd1;
               if (col_q == MM_IDX_W'(MM_DIM - 1)) begin
                  col_d = '0;
                  row_d = row_q + 2'd1;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end

         MM_ST_OUTPUT: begin
            if (out_fire) begin
               if (out_row_q == MM_IDX_W'(MM_DIM - 1)) begin
                  state_d     = MM_ST_LOAD_A;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  out_row_d  = out_row_nx;
                  out_data_d = res_q[out_row_nx];
                  out_idx_d  = out_row_nx;
                  out_last_d = (out_row_nx == MM_IDX_W'(MM_DIM - 1));
               end
            end
         end

         default: state_d = MM_ST_LOAD_A;
      endcase

      in_ready_d = mm_is_load(state_d);
      busy_d     = !((state_d == MM_ST_LOAD_A) && (ld_cnt_d == '0));
   end

   // Operand selection for the MAC.
   always_comb begin
      mac_a = a_q[mac_idx];
      mac_b = b_q[col_q];
   end

   // Counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt_q  <= '0;
         mac_cnt_q <= '0;
         col_q     <= '0;
         row_q     <= '0;
         out_row_q <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         ld_cnt_q  <= ld_cnt_d;
         mac_cnt_q <= mac_cnt_d;
         col_q     <= col_d;
         row_q     <= row_d;
         out_row_q <= out_row_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         out_idx   <= out_idx_d;
         out_last  <= out_last_d;
         in_ready  <= in_ready_d;
         busy      <= busy_d;
      end
   end

   // Operand and result buffers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MM_A_WORDS); i++) a_q[i] <= '0;
         for (int i = 0; i < int'(MM_DIM); i++) begin
            b_q[i]   <= '0;
            res_q[i] <= '0;
         end
      end else begin
         if (a_wr)   a_q[ld_cnt_q]        <= in_data;
         if (b_wr)   b_q[ld_cnt_q[1:0]]   <= in_data;
         if (res_wr) res_q[res_idx]       <= mac_acc;
      end
   end

endmodule

// File: tb/tb_mm_stream_mac.sv
// Directed testbench for mm_stream_mac: loads operand sets, checks results,
// handshake behaviour, latency, reset abort and back-to-back runs.
module tb_mm_stream_mac;

   localparam int unsigned NB = 8;
   localparam int unsigned RW = 18;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NB-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [RW-1:0] out_data;
   logic [1:0]    out_idx;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int first_valid_cyc = 0;

   logic [7:0] words [12];
   int         gaps  [12];

   mm_stream_mac #(.NBITS(NB), .RESULT_WIDTH(RW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   function automatic logic [31:0] r18(input int v);
      logic [RW-1:0] t;
      t = RW'(v);
      return {14'd0, t};
   endfunction

   // Offer one word after 'gap' idle cycles; returns at the negedge after acceptance.
   task automatic push(input logic [7:0] d, input int gap);
      int budget;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      budget   = 0;
      while (in_ready !== 1'b1 && budget < 60) begin
         @(negedge clk);
         budget++;
      end
      if (in_ready !== 1'b1) check("push in_ready timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      accept_cyc = cyc;
      in_valid   = 1'b0;
   endtask

   task automatic load(input bit use_gaps);
      for (int i = 0; i < 12; i++) push(words[i], use_gaps ? gaps[i] : 0);
   endtask

   // Collect three result beats; stall>0 holds out_ready low that many cycles per beat.
   task automatic collect(input int c0, input int c1, input int c2, input int stall,
                          input string tag);
      int exp_c [3];
      int budget;
      exp_c[0] = c0;
      exp_c[1] = c1;
      exp_c[2] = c2;
      out_ready = (stall == 0);
      for (int r = 0; r < 3; r++) begin
         budget = 0;
         while (out_valid !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
         end
         if (r == 0) first_valid_cyc = cyc;
         if (r > 0 && stall == 0) check({tag, " consecutive"}, 32'(budget), 32'd0);
         check({tag, " out_valid"}, 32'(out_valid), 32'd1);
         check({tag, " out_data"}, {14'd0, out_data}, r18(exp_c[r]));
         check({tag, " out_idx"}, 32'(out_idx), 32'(r));
         check({tag, " out_last"}, 32'(out_last), 32'(r == 2));
         check({tag, " in_ready low"}, 32'(in_ready), 32'd0);
         if (stall > 0) begin
            repeat (stall) begin
               @(negedge clk);
               check({tag, " held data"}, {14'd0, out_data}, r18(exp_c[r]));
               check({tag, " held idx"}, 32'(out_idx), 32'(r));
               check({tag, " held valid"}, 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      out_ready = 1'b1;
      check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_data", {14'd0, out_data}, 32'd0);
      check("rst out_idx", 32'(out_idx), 32'd0);
      check("rst out_last", 32'(out_last), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle in_ready", 32'(in_ready), 32'd1);
      check("idle busy", 32'(busy), 32'd0);

      // 1: identity * (1,2,3), no stalls, latency 10
      words = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01,
                8'h01, 8'h02, 8'h03};
      load(1'b0);
      check("t1 busy", 32'(busy), 32'd1);
      collect(1, 2, 3, 0, "t1");
      check("t1 latency", 32'(first_valid_cyc - accept_cyc), 32'd10);

      // 2: all -128 -> 49152 per row
      words = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
                8'h80, 8'h80, 8'h80};
      load(1'b0);
      collect(49152, 49152, 49152, 0, "t2");

      // 3: A=1..9, B=(-1,0,2) with input gaps
      words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                8'hFF, 8'h00, 8'h02};
      gaps  = '{0, 2, 1, 3, 0, 1, 0, 2, 1, 0, 3, 1};
      load(1'b1);
      collect(5, 8, 11, 0, "t3");

      // 4: same with output back-pressure
      load(1'b1);
      collect(5, 8, 11, 5, "t4");

      // 5: reset mid-load of A, then a fresh full load
      for (int i = 0; i < 6; i++) push(8'(i + 1), 0);
      check("t5 busy before rst", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5 rst out_valid", 32'(out_valid), 32'd0);
      check("t5 rst out_data", {14'd0, out_data}, 32'd0);
      check("t5 rst busy", 32'(busy), 32'd0);
      check("t5 rst out_idx", 32'(out_idx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5 in_ready", 32'(in_ready), 32'd1);
      words = '{8'h02, 8'hFD, 8'h04, 8'h00, 8'h05, 8'hFA, 8'h07, 8'h01, 8'hFF,
                8'h03, 8'hFE, 8'h01};
      load(1'b0);
      collect(16, -16, 18, 0, "t5");

      // 6: back-to-back runs, in_valid held high through COMPUTE/OUTPUT
      words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                8'hFF, 8'h00, 8'h02};
      load(1'b0);
      in_valid = 1'b1;
      in_data  = 8'h7F;
      repeat (4) begin
         @(negedge clk);
         check("t6 compute in_ready", 32'(in_ready), 32'd0);
      end
      collect(5, 8, 11, 0, "t6a");
      words = '{8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h01, 8'hFF, 8'h00,
                8'h7F, 8'h7F, 8'h7F};
      load(1'b0);
      collect(48387, -48768, 0, 0, "t6b");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
